// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state enum, access-size encodings and LSU type packing for the MEM stage
//   No ports: imported by mem_access_stage and load_extend.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   localparam int LSU_TYPE_W = 5;

   function automatic logic [3:0] size_to_bytes(input logic [1:0] size);
      return 4'd1 << size;
   endfunction

   // Byte count sits in [4:1]; bit 0 (LSU-side sign extension) is never requested
   // because extension is done in this stage.
   function automatic logic [LSU_TYPE_W-1:0] lsu_type_pack(input logic [1:0] size);
      return {size_to_bytes(size), 1'b0};
   endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - EX/LSU/WB signal bundle of the MEM stage
//   slave  : the MEM stage view (EX op in, LSU request out, LSU rdata in, WB result out)
//   master : the surrounding pipeline / LSU view
interface mem_access_stage_if #(
   parameter int XLEN = 64
);
   logic            ex_valid;
   logic            ex_ready;
   logic [XLEN-1:0] ex_addr;
   logic [XLEN-1:0] ex_wdata;
   logic [1:0]      ex_size;
   logic            ex_unsigned;
   logic            ex_is_load;
   logic            ex_is_store;
   logic [4:0]      ex_rd;
   logic [XLEN-1:0] ex_result;
   logic [XLEN-1:0] lsu_addr;
   logic [4:0]      lsu_type;
   logic            lsu_wen;
   logic [XLEN-1:0] lsu_wdata;
   logic [XLEN-1:0] lsu_rdata;
   logic            wb_valid;
   logic            wb_ready;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            wb_misalign;

   modport slave (
      input  ex_valid, ex_addr, ex_wdata, ex_size, ex_unsigned, ex_is_load, ex_is_store,
             ex_rd, ex_result, lsu_rdata, wb_ready,
      output ex_ready, lsu_addr, lsu_type, lsu_wen, lsu_wdata, wb_valid, wb_rd, wb_data,
             wb_misalign
   );

   modport master (
      output ex_valid, ex_addr, ex_wdata, ex_size, ex_unsigned, ex_is_load, ex_is_store,
             ex_rd, ex_result, lsu_rdata, wb_ready,
      input  ex_ready, lsu_addr, lsu_type, lsu_wen, lsu_wdata, wb_valid, wb_rd, wb_data,
             wb_misalign
   );
endinterface

// File: rtl/mem_access_stage_load_extend.sv
// rtl/mem_access_stage_load_extend.sv - combinational sign/zero extension of LSU read data
//   rdata_i    : raw read data, byte 0 = byte at the request address
//   size_i     : access size (SZ_B/SZ_H/SZ_W/SZ_D)
//   unsigned_i : 1 = zero-extend, 0 = sign-extend from bit 8*bytes-1
//   data_o     : extended result
module load_extend
   import mem_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] rdata_i,
   input  logic [1:0]      size_i,
   input  logic            unsigned_i,
   output logic [XLEN-1:0] data_o
);
   logic sign_fill;

   always_comb begin
      data_o    = rdata_i;
      sign_fill = 1'b0;
      case (size_i)
         SZ_B: begin
            sign_fill = ~unsigned_i & rdata_i[7];
            data_o    = {{(XLEN-8){sign_fill}}, rdata_i[7:0]};
         end
         SZ_H: begin
            sign_fill = ~unsigned_i & rdata_i[15];
            data_o    = {{(XLEN-16){sign_fill}}, rdata_i[15:0]};
         end
         SZ_W: begin
            sign_fill = ~unsigned_i & rdata_i[31];
            data_o    = {{(XLEN-32){sign_fill}}, rdata_i[31:0]};
         end
         default: data_o = rdata_i;
      endcase
   end
endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: issues one LSU request per op, waits MEM_LAT, extends loads, hands result to WB
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : mem_access_stage_if.slave (EX accept handshake, LSU request/rdata, WB handshake)
module mem_access_stage
   import mem_pkg::*;
#(
   parameter int MEM_LAT = 2,
   parameter int XLEN    = 64
) (
   input logic               clock,
   input logic               reset,
   mem_access_stage_if.slave bus
);
   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   state_e          state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]      size_q;
   logic            uns_q;
   logic            store_q;
   logic            ex_ready_q;
   logic            lsu_wen_q;
   logic            wb_valid_q;
   logic            wb_misalign_q;
   logic [XLEN-1:0] lsu_addr_q;
   logic [XLEN-1:0] lsu_wdata_q;
   logic [XLEN-1:0] wb_data_q;
   logic [4:0]      lsu_type_q;
   logic [4:0]      wb_rd_q;

   logic            mem_op_d;
   logic            store_d;
   logic            misalign_d;
   logic [XLEN-1:0] wmask_d;
   logic [XLEN-1:0] ext_data_d;

   // A op flagged both load and store is executed as a load.
   assign mem_op_d = bus.ex_is_load | bus.ex_is_store;
   assign store_d  = bus.ex_is_store & ~bus.ex_is_load;

   always_comb begin
      misalign_d = 1'b0;
      wmask_d    = '1;
      case (bus.ex_size)
         SZ_B: wmask_d = {{(XLEN-8){1'b0}}, 8'hFF};
         SZ_H: begin
            misalign_d = bus.ex_addr[0];
            wmask_d    = {{(XLEN-16){1'b0}}, 16'hFFFF};
         end
         SZ_W: begin
            misalign_d = |bus.ex_addr[1:0];
            wmask_d    = {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF};
         end
         default: misalign_d = |bus.ex_addr[2:0];
      endcase
   end

   load_extend #(.XLEN(XLEN)) u_load_extend (
      .rdata_i    (bus.lsu_rdata),
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .data_o     (ext_data_d)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         size_q        <= SZ_B;
         uns_q         <= 1'b0;
         store_q       <= 1'b0;
         ex_ready_q    <= 1'b1;
         lsu_wen_q     <= 1'b0;
         lsu_addr_q    <= '0;
         lsu_type_q    <= '0;
         lsu_wdata_q   <= '0;
         wb_valid_q    <= 1'b0;
         wb_rd_q       <= '0;
         wb_data_q     <= '0;
         wb_misalign_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.ex_valid) begin
                  size_q     <= bus.ex_size;
                  uns_q      <= bus.ex_unsigned;
                  store_q    <= store_d;
                  wb_rd_q    <= bus.ex_rd;
                  ex_ready_q <= 1'b0;
                  if (!mem_op_d) begin
                     wb_data_q     <= bus.ex_result;
                     wb_misalign_q <= 1'b0;
                     wb_valid_q    <= 1'b1;
                     state_q       <= RESP;
                  end else if (misalign_d) begin
                     // Misaligned: report straight away, LSU never sees the op.
                     wb_data_q     <= '0;
                     wb_misalign_q <= 1'b1;
                     wb_valid_q    <= 1'b1;
                     state_q       <= RESP;
                  end else begin
                     lsu_addr_q    <= bus.ex_addr;
                     lsu_type_q    <= lsu_type_pack(bus.ex_size);
                     lsu_wdata_q   <= bus.ex_wdata & wmask_d;
                     lsu_wen_q     <= store_d;
                     wb_misalign_q <= 1'b0;
                     cnt_q         <= CNT_W'(MEM_LAT - 1);
                     state_q       <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               // The LSU writes on every cycle wen is high, so the strobe only covers
               // the first ACCESS cycle.
               lsu_wen_q <= 1'b0;
               if (cnt_q == '0) begin
                  wb_data_q   <= store_q ? '0 : ext_data_d;
                  wb_valid_q  <= 1'b1;
                  lsu_addr_q  <= '0;
                  lsu_type_q  <= '0;
                  lsu_wdata_q <= '0;
                  state_q     <= RESP;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            RESP: begin
               if (bus.wb_ready) begin
                  wb_valid_q <= 1'b0;
                  ex_ready_q <= 1'b1;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.ex_ready    = ex_ready_q;
   assign bus.lsu_addr    = lsu_addr_q;
   assign bus.lsu_type    = lsu_type_q;
   assign bus.lsu_wen     = lsu_wen_q;
   assign bus.lsu_wdata   = lsu_wdata_q;
   assign bus.wb_valid    = wb_valid_q;
   assign bus.wb_rd       = wb_rd_q;
   assign bus.wb_data     = wb_data_q;
   assign bus.wb_misalign = wb_misalign_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage with byte-memory LSU model
module tb_mem_access_stage;
   localparam int MEM_LAT = 2;
   localparam int XLEN    = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_access_stage_if #(.XLEN(XLEN)) bus ();

   mem_access_stage #(.MEM_LAT(MEM_LAT), .XLEN(XLEN)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   // LSU memory model: 64 bytes, address taken modulo 64.
   logic [7:0]      mem [0:63];
   logic            pre_we   = 1'b0;
   logic [5:0]      pre_idx  = '0;
   logic [63:0]     pre_word = '0;
   int              writes   = 0;
   longint unsigned cyc      = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.lsu_wen) begin
         writes <= writes + 1;
         for (int i = 0; i < 8; i++)
            if (i < int'(bus.lsu_type[4:1]))
               mem[6'(bus.lsu_addr[5:0] + 6'(i))] <= bus.lsu_wdata[8*i +: 8];
      end
      if (pre_we)
         for (int i = 0; i < 8; i++) mem[pre_idx + 6'(i)] <= pre_word[8*i +: 8];
   end

   always_comb begin
      bus.lsu_rdata = '0;
      for (int i = 0; i < 8; i++)
         bus.lsu_rdata[8*i +: 8] = mem[6'(bus.lsu_addr[5:0] + 6'(i))];
   end

   // Expected behaviour of the op in flight, in terms of cycles since acceptance.
   logic            e_store, e_mis;
   logic [63:0]     e_addr, e_wdata_m, e_wb;
   logic [4:0]      e_rd, e_type;
   int              e_r0, e_bp;
   longint unsigned acc_cyc = 0;
   bit              active = 0, done = 0;
   logic [63:0]     cap_wb, cap_wdata;
   logic [4:0]      cap_type;
   logic            cap_mis;
   int              wen_cnt;
   int              vectors = 0, miscompares = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] mem_word(input logic [5:0] a);
      logic [63:0] v;
      for (int i = 0; i < 8; i++) v[8*i +: 8] = mem[a + 6'(i)];
      return v;
   endfunction

   task automatic chk_lsu_idle(input string ph);
      chk({ph, "_lsu_wen"},   64'(bus.lsu_wen),  64'd0);
      chk({ph, "_lsu_type"},  64'(bus.lsu_type), 64'd0);
      chk({ph, "_lsu_addr"},  bus.lsu_addr,      64'd0);
      chk({ph, "_lsu_wdata"}, bus.lsu_wdata,     64'd0);
   endtask

   task automatic chk_reset(input string ph);
      chk_lsu_idle(ph);
      chk({ph, "_ex_ready"},    64'(bus.ex_ready),    64'd1);
      chk({ph, "_wb_valid"},    64'(bus.wb_valid),    64'd0);
      chk({ph, "_wb_data"},     bus.wb_data,          64'd0);
      chk({ph, "_wb_rd"},       64'(bus.wb_rd),       64'd0);
      chk({ph, "_wb_misalign"}, 64'(bus.wb_misalign), 64'd0);
   endtask

   task automatic check_cycle();
      int n = int'(cyc - acc_cyc);
      if (n < e_r0) begin
         chk("acc_ex_ready",  64'(bus.ex_ready), 64'd0);
         chk("acc_wb_valid",  64'(bus.wb_valid), 64'd0);
         chk("acc_lsu_addr",  bus.lsu_addr, e_addr);
         chk("acc_lsu_type",  64'(bus.lsu_type), 64'(e_type));
         chk("acc_lsu_wen",   64'(bus.lsu_wen), 64'(e_store && (n == 0)));
         chk("acc_lsu_wdata", bus.lsu_wdata, e_wdata_m);
         if (n == 0) begin
            cap_type  = bus.lsu_type;
            cap_wdata = bus.lsu_wdata;
         end
      end else if (n <= e_r0 + e_bp) begin
         chk_lsu_idle("resp");
         chk("resp_ex_ready",    64'(bus.ex_ready), 64'd0);
         chk("resp_wb_valid",    64'(bus.wb_valid), 64'd1);
         chk("resp_wb_rd",       64'(bus.wb_rd), 64'(e_rd));
         chk("resp_wb_data",     bus.wb_data, e_wb);
         chk("resp_wb_misalign", 64'(bus.wb_misalign), 64'(e_mis));
         if (n == e_r0) begin
            cap_wb  = bus.wb_data;
            cap_mis = bus.wb_misalign;
         end
      end else begin
         chk_lsu_idle("idle");
         chk("idle_ex_ready", 64'(bus.ex_ready), 64'd1);
         chk("idle_wb_valid", 64'(bus.wb_valid), 64'd0);
      end
      if (bus.lsu_wen) wen_cnt++;
   endtask

   task automatic preload(input logic [5:0] idx, input logic [63:0] w);
      pre_idx = idx; pre_word = w; pre_we = 1'b1;
      @(posedge clk); #1;
      pre_we = 1'b0;
   endtask

   // Issue one op at posedge+1 phase; returns at posedge+1 once the op has left RESP
   // (or after an asynchronous reset injected abort_at cycles after acceptance).
   task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] result,
                        input logic [4:0] rd, input int bp, input int abort_at);
      int nb = 1 << sz;
      int w = 0;
      int n = 0;
      int wr0;
      logic mem_op = ld | st;
      logic m_store = st & ~ld;
      logic m_mis = mem_op && ((addr % 64'(nb)) != 64'd0);
      logic [63:0] m_wdata, m_wb, v;
      if (nb == 8) m_wdata = wdata; else m_wdata = wdata % (64'd1 << (8*nb));
      if (!mem_op) m_wb = result;
      else if (m_mis || m_store) m_wb = 64'd0;
      else begin
         v = mem_word(addr[5:0]);
         if (nb < 8) begin
            v = v % (64'd1 << (8*nb));
            if (!uns && v >= (64'd1 << (8*nb - 1))) v = v - (64'd1 << (8*nb));
         end
         m_wb = v;
      end
      while (!bus.ex_ready && w < 20) begin @(posedge clk); #1; w++; end
      chk("ex_ready_before_issue", 64'(bus.ex_ready), 64'd1);
      bus.ex_valid = 1'b1; bus.ex_is_load = ld; bus.ex_is_store = st; bus.ex_size = sz;
      bus.ex_unsigned = uns; bus.ex_addr = addr; bus.ex_wdata = wdata;
      bus.ex_result = result; bus.ex_rd = rd;
      @(posedge clk); #1;
      acc_cyc = cyc; wen_cnt = 0; active = 1;
      e_store = m_store; e_mis = m_mis; e_addr = addr; e_wdata_m = m_wdata; e_wb = m_wb;
      e_rd = rd; e_type = 5'(2 * nb); e_r0 = (mem_op && !m_mis) ? MEM_LAT : 0; e_bp = bp;
      bus.ex_valid = 1'b0;
      bus.ex_addr = {$urandom, $urandom}; bus.ex_result = {$urandom, $urandom};
      bus.ex_rd = 5'($urandom);
      bus.wb_ready = (n >= e_r0 + e_bp);
      while (n <= e_r0 + e_bp) begin
         if (n == abort_at) begin
            wr0 = writes;
            rst = 1'b1;
            active = 0;
            #1;
            chk_reset("async_rst");
            repeat (2) @(posedge clk);
            #1;
            chk("abort_no_more_writes", 64'(writes - wr0), 64'd0);
            chk_reset("rst_held");
            @(negedge clk);
            rst = 1'b0;
            bus.wb_ready = 1'b1;
            @(posedge clk); #1;
            return;
         end
         @(posedge clk); #1;
         n = int'(cyc - acc_cyc);
         bus.wb_ready = (n >= e_r0 + e_bp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      longint unsigned t0;
      int wr0;
      bus.ex_valid = 1'b0; bus.ex_is_load = 1'b0; bus.ex_is_store = 1'b0; bus.ex_size = 2'd0;
      bus.ex_unsigned = 1'b0; bus.ex_addr = '0; bus.ex_wdata = '0; bus.ex_result = '0;
      bus.ex_rd = '0; bus.wb_ready = 1'b1;
      fork
         begin
            while (!done) begin
               @(negedge clk);
               if (active && !rst) check_cycle();
            end
         end
         begin
            for (int i = 0; i < 8; i++) preload(6'(8 * i), 64'd0);
            chk_reset("por");
            @(negedge clk); rst = 1'b0;
            @(posedge clk); #1;
            chk_reset("after_release");

            // Signed byte load
            preload(6'd0, 64'h0000_0000_8000_0000);
            t0 = cyc;
            issue(1, 0, 2'd0, 0, 64'h8000_0003, 64'd0, 64'd0, 5'd5, 0, -1);
            chk("t1_wb_data", cap_wb, 64'hFFFF_FFFF_FFFF_FF80);
            chk("t1_lsu_type", 64'(cap_type), 64'(5'b00010));
            chk("t1_wen_cnt", 64'(wen_cnt), 64'd0);
            chk("t1_cycles", cyc - t0, 64'(MEM_LAT + 2));

            // Halfword loads, unsigned and signed
            preload(6'd0, 64'h0000_0000_F00D_0000);
            issue(1, 0, 2'd1, 1, 64'h8000_0002, 64'd0, 64'd0, 5'd6, 0, -1);
            chk("t2_lhu", cap_wb, 64'h0000_0000_0000_F00D);
            issue(1, 0, 2'd1, 0, 64'h8000_0002, 64'd0, 64'd0, 5'd6, 0, -1);
            chk("t2_lh", cap_wb, 64'hFFFF_FFFF_FFFF_F00D);

            // Word store: one strobe, masked data
            wr0 = writes;
            issue(0, 1, 2'd2, 0, 64'h8000_0004, 64'h1122_3344_5566_7788, 64'd0, 5'd7, 0, -1);
            chk("t3_lsu_wdata", cap_wdata, 64'h0000_0000_5566_7788);
            chk("t3_lsu_type", 64'(cap_type), 64'(5'b01000));
            chk("t3_wen_cnt", 64'(wen_cnt), 64'd1);
            chk("t3_writes", 64'(writes - wr0), 64'd1);
            chk("t3_wb_data", cap_wb, 64'd0);

            // Doubleword readback held under 5 cycles of backpressure, then a non-mem op
            issue(1, 0, 2'd3, 0, 64'h8000_0000, 64'd0, 64'd0, 5'd8, 5, -1);
            chk("t5_ld_bp", cap_wb, 64'h5566_7788_F00D_0000);
            t0 = cyc;
            issue(0, 0, 2'd3, 0, 64'h8000_0001, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 5'd31, 0, -1);
            chk("t5_alu", cap_wb, 64'hDEAD_BEEF_CAFE_F00D);
            chk("t5_alu_cycles", cyc - t0, 64'd2);

            // Misaligned word load and halfword store
            wr0 = writes;
            t0 = cyc;
            issue(1, 0, 2'd2, 0, 64'h8000_0002, 64'd0, 64'd0, 5'd9, 0, -1);
            chk("t4_misalign", 64'(cap_mis), 64'd1);
            chk("t4_wb_data", cap_wb, 64'd0);
            chk("t4_cycles", cyc - t0, 64'd2);
            issue(0, 1, 2'd1, 0, 64'h8000_0009, 64'hFFFF, 64'd0, 5'd9, 0, -1);
            chk("t4_st_misalign", 64'(cap_mis), 64'd1);
            chk("t4_writes", 64'(writes - wr0), 64'd0);

            // Load and store both set: behaves as a signed word load
            preload(6'd8, 64'h0000_0000_8765_4321);
            wr0 = writes;
            issue(1, 1, 2'd2, 0, 64'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 5'd3, 0, -1);
            chk("t6_ldst", cap_wb, 64'hFFFF_FFFF_8765_4321);
            chk("t6_writes", 64'(writes - wr0), 64'd0);

            // Byte store then unsigned byte readback
            issue(0, 1, 2'd0, 0, 64'h8000_0009, 64'h1234_5678_9ABC_DEA5, 64'd0, 5'd4, 0, -1);
            chk("t6_sb_wdata", cap_wdata, 64'h0000_0000_0000_00A5);
            issue(1, 0, 2'd0, 1, 64'h8000_0009, 64'd0, 64'd0, 5'd4, 2, -1);
            chk("t6_lbu", cap_wb, 64'h0000_0000_0000_00A5);

            // Async reset in the second ACCESS cycle of a doubleword store
            wr0 = writes;
            issue(0, 1, 2'd3, 0, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 64'd0, 5'd2, 0, 1);
            chk("t7_one_write", 64'(writes - wr0), 64'd1);
            chk_reset("t7_after");
            issue(1, 0, 2'd3, 0, 64'h8000_0010, 64'd0, 64'd0, 5'd1, 0, -1);
            chk("t7_readback", cap_wb, 64'h0123_4567_89AB_CDEF);

            done = 1;
         end
      join
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
